horner_eval_q16: RTL and testbench

Sequential Horner-scheme polynomial evaluator in Q16.16 fixed point: y = c0 + x·(c1 + x·(c2 + … + x·c[DEGREE])). It drives one Q16 multiplier instance and consumes its product through an iterative accumulate loop, one Horner step per clock. It holds a small coefficient register file, accepts x over a valid/ready input, and returns y over a valid/ready output.

---
 rtl/horner_eval_q16.sv | 125 ++++++++++++
 tb/tb_horner_eval_q16.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/horner_eval_q16.sv
// horner_eval_q16: sequential Horner evaluator in signed Q16.16.
//   y = c0 + x*(c1 + x*(c2 + ... + x*c[DEGREE]))
// One multiply-accumulate step per clock through a single Q16 multiplier.
// Coefficients live in a small register file written only while idle.
// x arrives on a valid/ready port, and y leaves on a valid/ready port.
module horner_eval_q16 #(
  parameter int DEGREE = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        coef_we,
  input  logic [3:0]  coef_addr,
  input  logic [31:0] coef_wdata,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_x,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_y,
  output logic        busy
);

  localparam int DATA_W = 32;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  // Degree 0 has no Horner steps, so the accepted x goes straight to DONE.
  localparam logic [1:0] S_AFTER_ACCEPT = (DEGREE == 0) ? S_DONE : S_RUN;
  localparam logic [3:0] IDX_START      = (DEGREE == 0) ? 4'd0 : 4'(DEGREE - 1);

  logic [1:0]               state;
  logic signed [DATA_W-1:0] x_reg;
  logic signed [DATA_W-1:0] acc;
  logic [3:0]               idx;

  logic signed [DATA_W-1:0] coef [DEGREE+1];
  logic signed [DATA_W-1:0] coef_rd;
  logic signed [DATA_W-1:0] coef_top;
  logic                     coef_wr;

  // Q16 multiply: full 64-bit signed product with an arithmetic shift right
  // of 16 (floor rounding), keeping the low 32 bits. There is no saturation.
  function automatic logic signed [DATA_W-1:0] mul_q16(
    input logic signed [DATA_W-1:0] a,
    input logic signed [DATA_W-1:0] b
  );
    logic signed [2*DATA_W-1:0] ae;
    logic signed [2*DATA_W-1:0] be;
    logic signed [2*DATA_W-1:0] prod;
    ae   = a;
    be   = b;
    prod = ae * be;
    return DATA_W'(prod >>> 16);
  endfunction

  // Two's-complement add that wraps on overflow.
  function automatic logic signed [DATA_W-1:0] add_wrap(
    input logic signed [DATA_W-1:0] a,
    input logic signed [DATA_W-1:0] b
  );
    return a + b;
  endfunction

  // Writes are accepted only in IDLE, outside the accept cycle, and in range.
  assign coef_wr = coef_we && (state == S_IDLE) && !in_valid &&
                   ({28'd0, coef_addr} <= 32'(DEGREE));

  // Coefficient register file; it is cleared by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i <= DEGREE; i++) coef[i] <= '0;
    end else if (coef_wr) begin
      for (int i = 0; i <= DEGREE; i++)
        if (coef_addr == 4'(i)) coef[i] <= coef_wdata;
    end
  end

  // Read port for the Horner step coefficient c[idx].
  always_comb begin
    coef_rd = '0;
    for (int i = 0; i <= DEGREE; i++)
      if (idx == 4'(i)) coef_rd = coef[i];
  end

  assign coef_top = coef[DEGREE];

  // Control and datapath: load on accept, one Horner step per RUN cycle,
  // then hold the result in acc until the consumer takes it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      x_reg <= '0;
      acc   <= '0;
      idx   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            x_reg <= in_x;
            acc   <= coef_top;
            idx   <= IDX_START;
            state <= S_AFTER_ACCEPT;
          end
        end
        S_RUN: begin
          acc <= add_wrap(mul_q16(acc, x_reg), coef_rd);
          if (idx == 4'd0) state <= S_DONE;
          else             idx   <= idx - 4'd1;
        end
        S_DONE: begin
          if (out_ready) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign in_ready  = (state == S_IDLE);
  assign busy      = (state != S_IDLE);
  assign out_valid = (state == S_DONE);
  assign out_y     = acc;

endmodule

// File: tb/tb_horner_eval_q16.sv
// tb_horner_eval_q16: directed checks for horner_eval_q16 at DEGREE 2, 4 and 0.
// Index 0 is DEGREE=2, index 1 is DEGREE=4, and index 2 is DEGREE=0.
module tb_horner_eval_q16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [2:0]        rst, coef_we, in_valid, in_ready, out_valid, out_ready, busy;
  logic [2:0][3:0]   coef_addr;
  logic [2:0][31:0]  coef_wdata, in_x, out_y;

  int n_chk  = 0;
  int n_fail = 0;
  int degs [3] = '{2, 4, 0};

  horner_eval_q16 #(.DEGREE(2)) u_deg2 (
    .clk(clk), .rst(rst[0]), .coef_we(coef_we[0]), .coef_addr(coef_addr[0]),
    .coef_wdata(coef_wdata[0]), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .in_x(in_x[0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
    .out_y(out_y[0]), .busy(busy[0]));

  horner_eval_q16 #(.DEGREE(4)) u_deg4 (
    .clk(clk), .rst(rst[1]), .coef_we(coef_we[1]), .coef_addr(coef_addr[1]),
    .coef_wdata(coef_wdata[1]), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .in_x(in_x[1]), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
    .out_y(out_y[1]), .busy(busy[1]));

  horner_eval_q16 #(.DEGREE(0)) u_deg0 (
    .clk(clk), .rst(rst[2]), .coef_we(coef_we[2]), .coef_addr(coef_addr[2]),
    .coef_wdata(coef_wdata[2]), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
    .in_x(in_x[2]), .out_valid(out_valid[2]), .out_ready(out_ready[2]),
    .out_y(out_y[2]), .busy(busy[2]));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h, expected %08h", tag, got, exp);
    end
  endtask

  // Each task is entered and left just after a falling edge.
  task automatic wr(input int d, input logic [3:0] a, input logic [31:0] v);
    coef_we[d]    = 1'b1;
    coef_addr[d]  = a;
    coef_wdata[d] = v;
    @(negedge clk);
    coef_we[d]    = 1'b0;
  endtask

  task automatic start(input int d, input logic [31:0] x);
    chk("in_ready before accept", 32'(in_ready[d]), 32'd1);
    in_valid[d] = 1'b1;
    in_x[d]     = x;
    @(negedge clk);
    in_valid[d] = 1'b0;
    chk("busy after accept", 32'(busy[d]), 32'd1);
    chk("in_ready after accept", 32'(in_ready[d]), 32'd0);
  endtask

  task automatic wait_out(input int d, output logic [31:0] y, output int n);
    n = 0;
    while (!out_valid[d] && n < 64) begin
      @(negedge clk);
      n++;
    end
    chk("out_valid within budget", 32'(out_valid[d]), 32'd1);
    y = out_y[d];
  endtask

  task automatic finish_out(input int d);
    @(negedge clk);
    chk("out_valid after handshake", 32'(out_valid[d]), 32'd0);
    chk("in_ready after handshake", 32'(in_ready[d]), 32'd1);
  endtask

  task automatic eval(input int d, input logic [31:0] x, input logic [31:0] exp,
                      input string tag);
    logic [31:0] y;
    int n;
    start(d, x);
    wait_out(d, y, n);
    chk(tag, y, exp);
    chk({tag, " latency"}, 32'(n), 32'(degs[d]));
    finish_out(d);
  endtask

  initial begin
    logic [31:0] y;
    int n;
    int seen;

    rst        = 3'b111;
    coef_we    = '0;
    coef_addr  = '0;
    coef_wdata = '0;
    in_valid   = '0;
    in_x       = '0;
    out_ready  = 3'b111;
    repeat (2) @(negedge clk);
    rst = 3'b000;

    for (int d = 0; d < 3; d++) begin
      chk("reset out_valid", 32'(out_valid[d]), 32'd0);
      chk("reset out_y", out_y[d], 32'd0);
      chk("reset in_ready", 32'(in_ready[d]), 32'd1);
      chk("reset busy", 32'(busy[d]), 32'd0);
    end

    // Basic evaluation: 1 + 2x + 3x^2 at x=2 gives 17.
    wr(0, 4'd0, 32'h0001_0000);
    wr(0, 4'd1, 32'h0002_0000);
    wr(0, 4'd2, 32'h0003_0000);
    eval(0, 32'h0002_0000, 32'h0011_0000, "basic deg2");

    // Floor rounding: 1 ulp times -0.5 gives -1 ulp.
    wr(0, 4'd2, 32'h0000_0000);
    wr(0, 4'd1, 32'h0000_0001);
    wr(0, 4'd0, 32'h0000_0000);
    eval(0, 32'hFFFF_8000, 32'hFFFF_FFFF, "floor rounding");

    // Wraparound: 0x7FFF0000*2 wraps to 0xFFFE0000, then *2 gives 0xFFFC0000.
    wr(0, 4'd2, 32'h7FFF_0000);
    wr(0, 4'd1, 32'h0000_0000);
    start(0, 32'h0002_0000);
    @(negedge clk);
    chk("wrap intermediate acc", out_y[0], 32'hFFFE_0000);
    wait_out(0, y, n);
    chk("wrap result", y, 32'hFFFC_0000);
    finish_out(0);

    // Backpressure: the result is held, and new x pulses are ignored.
    wr(0, 4'd0, 32'h0001_0000);
    wr(0, 4'd1, 32'h0002_0000);
    wr(0, 4'd2, 32'h0003_0000);
    out_ready[0] = 1'b0;
    start(0, 32'h0002_0000);
    wait_out(0, y, n);
    chk("bp first result", y, 32'h0011_0000);
    for (int i = 0; i < 5; i++) begin
      in_valid[0] = (i % 2 == 0);
      in_x[0]     = 32'h0003_0000;
      @(negedge clk);
      chk("bp out_valid held", 32'(out_valid[0]), 32'd1);
      chk("bp out_y held", out_y[0], 32'h0011_0000);
      chk("bp in_ready low", 32'(in_ready[0]), 32'd0);
    end
    in_valid[0]  = 1'b0;
    out_ready[0] = 1'b1;
    finish_out(0);
    eval(0, 32'h0003_0000, 32'h0022_0000, "bp second x");

    // Dropped writes: while busy, in the accept cycle, and out of range.
    start(0, 32'h0002_0000);
    wr(0, 4'd0, 32'h0005_0000);
    wait_out(0, y, n);
    chk("write while busy dropped", y, 32'h0011_0000);
    finish_out(0);

    coef_we[0]    = 1'b1;
    coef_addr[0]  = 4'd0;
    coef_wdata[0] = 32'h0005_0000;
    start(0, 32'h0002_0000);
    coef_we[0]    = 1'b0;
    wait_out(0, y, n);
    chk("write in accept cycle dropped", y, 32'h0011_0000);
    finish_out(0);

    wr(0, 4'd7, 32'h0005_0000);
    wr(0, 4'd3, 32'h0005_0000);
    eval(0, 32'h0002_0000, 32'h0011_0000, "out-of-range writes dropped");

    // DEGREE=0: the result is c0, with out_valid right after accept.
    wr(2, 4'd0, 32'h0007_0000);
    eval(2, 32'h0001_2345, 32'h0007_0000, "deg0 result");

    // DEGREE=4: all coefficients are 1.0.
    for (int i = 0; i < 5; i++) wr(1, 4'(i), 32'h0001_0000);
    eval(1, 32'h0001_0000, 32'h0005_0000, "deg4 x=1");
    eval(1, 32'h0002_0000, 32'h001F_0000, "deg4 x=2");

    // Reset two cycles after accept aborts and clears the coefficients.
    start(1, 32'h0002_0000);
    @(negedge clk);
    rst[1] = 1'b1;
    @(negedge clk);
    rst[1] = 1'b0;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      if (out_valid[1]) seen = 1;
      @(negedge clk);
    end
    chk("no out_valid after reset", 32'(seen), 32'd0);
    chk("in_ready after reset", 32'(in_ready[1]), 32'd1);
    chk("busy after reset", 32'(busy[1]), 32'd0);
    chk("out_y after reset", out_y[1], 32'd0);
    eval(1, 32'h0002_0000, 32'h0000_0000, "coefs cleared by reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
